// File: rtl/ccff_pkg.sv
// ccff_pkg: loader state encoding, byte width and bit-order helper
package ccff_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  function automatic logic [BYTE_W-1:0] rev_byte(input logic [BYTE_W-1:0] b);
    return {<<{b}};
  endfunction
endpackage

// File: rtl/ccff_loader_if.sv
// ccff_loader_if: host byte stream, chain serial port and status of the configuration loader
//   master: host/fabric side (start, verify, din, din_valid, ccff_tail)
//   slave:  loader side (din_ready, ccff_head, ccff_shift_en, busy, done, err, fabric_reset)
interface ccff_loader_if;
  import ccff_pkg::*;
  logic start;
  logic verify;
  logic [BYTE_W-1:0] din;
  logic din_valid;
  logic din_ready;
  logic ccff_head;
  logic ccff_shift_en;
  logic ccff_tail;
  logic busy;
  logic done;
  logic err;
  logic fabric_reset;
  modport master (
    output start, verify, din, din_valid, ccff_tail,
    input  din_ready, ccff_head, ccff_shift_en, busy, done, err, fabric_reset
  );
  modport slave (
    input  start, verify, din, din_valid, ccff_tail,
    output din_ready, ccff_head, ccff_shift_en, busy, done, err, fabric_reset
  );
endinterface

// File: rtl/ccff_loader.sv
// ccff_loader: serialises a host byte stream into the fabric configuration chain
//   prog_clk, prog_reset: programming clock, synchronous active-high reset
//   bus (slave): start/verify control, din/din_valid/din_ready handshake,
//                ccff_head/ccff_shift_en/ccff_tail chain port, busy/done/err/fabric_reset status
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 512,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic prog_clk,
  input logic prog_reset,
  ccff_loader_if.slave bus
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(BYTE_W);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [BYTE_W-1:0] r_sr;
  logic [IW-1:0] r_idx;
  logic r_verify;
  logic r_ready;
  logic r_head;
  logic r_shift;
  logic r_busy;
  logic r_done;
  logic r_err;
  logic r_fres;
  logic [BYTE_W-1:0] w_byte;
  logic w_err;
  logic w_last;
  // r_sr always holds the not-yet-shifted bits with the next one at bit 0
  assign w_byte = LSB_FIRST ? bus.din : rev_byte(bus.din);
  // the chain delay equals CHAIN_LEN, so the tail carries the previous load's bit for this shift
  assign w_err = r_err | (r_verify & (bus.ccff_tail ^ r_head));
  assign w_last = r_cnt == CW'(CHAIN_LEN - 1);
  assign bus.din_ready = r_ready;
  assign bus.ccff_head = r_head;
  assign bus.ccff_shift_en = r_shift;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err = r_err;
  assign bus.fabric_reset = r_fres;
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sr <= '0;
      r_idx <= '0;
      r_verify <= 1'b0;
      r_ready <= 1'b0;
      r_head <= 1'b0;
      r_shift <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_fres <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: if (bus.start) begin
          r_state <= FETCH;
          r_verify <= bus.verify;
          r_cnt <= '0;
          r_done <= 1'b0;
          r_err <= 1'b0;
          r_fres <= 1'b1;
          r_busy <= 1'b1;
          r_ready <= 1'b1;
        end
        FETCH: if (bus.din_valid) begin
          r_state <= SHIFT;
          r_sr <= w_byte;
          r_idx <= '0;
          r_head <= w_byte[0];
          r_shift <= 1'b1;
          r_ready <= 1'b0;
        end
        SHIFT: begin
          r_cnt <= r_cnt + CW'(1);
          r_idx <= r_idx + IW'(1);
          r_err <= w_err;
          r_sr <= r_sr >> 1;
          r_head <= r_sr[1];
          if (w_last) begin
            r_state <= DONE;
            r_shift <= 1'b0;
            r_head <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_fres <= w_err;
          end else if (r_idx == IW'(BYTE_W - 1)) begin
            r_state <= FETCH;
            r_shift <= 1'b0;
            r_head <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: drives a 16-bit and a 12-bit chain loader with shared stimulus against a bit-queue model
module tb_ccff_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic verify = 1'b0;
  logic din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic rdy[2], sh[2], head[2], tail[2], bsy[2], dn[2], er[2], fr[2];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] cap[2];
  int ncap[2], t_start[2], t_done[2], t_err[2];
  bit q[2][$];
  bit mb[2], md[2], me[2], mf[2], mv[2], pd[2], pe[2];
  int nsh[2], npush[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = g ? 12 : 16;
    logic [L-1:0] chain = '0;
    ccff_loader_if bus ();
    assign bus.start = start;
    assign bus.verify = verify;
    assign bus.din = din;
    assign bus.din_valid = din_valid;
    assign bus.ccff_tail = chain[L-1];
    assign rdy[g] = bus.din_ready;
    assign sh[g] = bus.ccff_shift_en;
    assign head[g] = bus.ccff_head;
    assign tail[g] = bus.ccff_tail;
    assign bsy[g] = bus.busy;
    assign dn[g] = bus.done;
    assign er[g] = bus.err;
    assign fr[g] = bus.fabric_reset;
    always @(posedge clk) if (bus.ccff_shift_en) chain <= {chain[L-2:0], bus.ccff_head};
    ccff_loader #(.CHAIN_LEN(L), .LSB_FIRST(1'b1)) dut (.prog_clk(clk), .prog_reset(rst), .bus(bus));
  end

  function automatic int len(input int i);
    return i == 1 ? 12 : 16;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the bits of each accepted byte (up to the chain length) queue up and leave one per cycle.
  task automatic monitor();
    bit armed = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        bit es;
        logic [6:0] got, exp;
        es = q[i].size() > 0;
        if (armed) begin
          got = {bsy[i], dn[i], er[i], fr[i], rdy[i], sh[i], sh[i] & head[i]};
          exp = {mb[i], md[i], me[i], mf[i], mb[i] & !es, es, es ? q[i][0] : 1'b0};
          chk($sformatf("outputs[%0d]", i), 32'(got), 32'(exp));
        end
        if (dn[i] && !pd[i]) t_done[i] = cyc;
        if (er[i] && !pe[i]) t_err[i] = cyc;
        pd[i] = dn[i];
        pe[i] = er[i];
        if (sh[i]) begin
          cap[i] = {cap[i][14:0], head[i]};
          ncap[i]++;
        end
        if (rst) begin
          q[i].delete();
          mb[i] = 1'b0;
          md[i] = 1'b0;
          me[i] = 1'b0;
          mf[i] = 1'b1;
          cap[i] = '0;
          ncap[i] = 0;
        end else if (es) begin
          if (mv[i] && tail[i] != q[i][0]) me[i] = 1'b1;
          void'(q[i].pop_front());
          nsh[i]++;
          if (nsh[i] == len(i)) begin
            mb[i] = 1'b0;
            md[i] = 1'b1;
            mf[i] = me[i];
          end
        end else if (mb[i] && din_valid) begin
          for (int b = 0; b < 8 && npush[i] < len(i); b++) begin
            q[i].push_back(din[b]);
            npush[i]++;
          end
        end else if (!mb[i] && start) begin
          mb[i] = 1'b1;
          md[i] = 1'b0;
          me[i] = 1'b0;
          mf[i] = 1'b1;
          mv[i] = verify;
          nsh[i] = 0;
          npush[i] = 0;
          cap[i] = '0;
          ncap[i] = 0;
          t_start[i] = cyc;
        end
      end
      if (rst) armed = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    din = b;
    din_valid = 1'b1;
    @(negedge clk);
    while (rdy[0] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept", 32'(t < 50), 32'd1);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!(dn[0] === 1'b1 && dn[1] === 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 32'(t < 100), 32'd1);
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic v);
    tick();
    start = 1'b1;
    verify = v;
    tick();
    start = 1'b0;
    send(b0);
    send(b1);
    wait_done();
  endtask

  initial begin
    int t;
    int n;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 32'({bsy[0], dn[0], er[0], fr[0], rdy[0], sh[0], head[0]}), 32'b0001000);
    tick();
    din = 8'hEE;
    din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid_ready", 32'(rdy[0]), 32'd0);
      chk("idle_valid_shift", 32'(sh[0]), 32'd0);
    end
    tick();
    din_valid = 1'b0;
    load(8'hA5, 8'h3C, 1'b0);
    chk("full_head_seq", 32'(cap[0]), 32'hA53C);
    chk("full_shift_count", 32'(ncap[0]), 32'd16);
    chk("full_done_cycles", 32'(t_done[0] - t_start[0]), 32'd19);
    chk("full_fabric_reset", 32'(fr[0]), 32'd0);
    chk("full12_head_seq", 32'(cap[1][11:0]), 32'hA53);
    load(8'hA5, 8'h3C, 1'b1);
    chk("verify_ok_err16", 32'(er[0]), 32'd0);
    chk("verify_ok_err12", 32'(er[1]), 32'd0);
    chk("verify_ok_fres16", 32'(fr[0]), 32'd0);
    chk("verify_ok_fres12", 32'(fr[1]), 32'd0);
    load(8'hA5, 8'h3D, 1'b1);
    chk("verify_bad_err16", 32'(er[0]), 32'd1);
    chk("verify_bad_fres16", 32'(fr[0]), 32'd1);
    chk("verify_bad_err_cycle", 32'(t_err[0] - t_start[0]), 32'd12);
    chk("verify_bad_fres12", 32'(fr[1]), 32'd1);
    load(8'hFF, 8'h0F, 1'b0);
    chk("partial_shift_count", 32'(ncap[1]), 32'd12);
    chk("partial_head_seq", 32'(cap[1][11:0]), 32'hFFF);
    chk("partial_done_cycles", 32'(t_done[1] - t_start[1]), 32'd15);
    chk("partial_fres", 32'(fr[1]), 32'd0);
    chk("partial16_head_seq", 32'(cap[0]), 32'hFFF0);
    tick();
    start = 1'b1;
    verify = 1'b0;
    tick();
    start = 1'b0;
    send(8'h12);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (rdy[0] !== 1'b1 && t < 20);
    chk("gap_fetch_reached", 32'(t < 20), 32'd1);
    repeat (4) begin
      chk("gap_shift_en", 32'(sh[0]), 32'd0);
      chk("gap_ready", 32'(rdy[0]), 32'd1);
      @(negedge clk);
    end
    tick();
    send(8'h34);
    wait_done();
    chk("gap_head_seq", 32'(cap[0]), 32'h482C);
    chk("gap_shift_count", 32'(ncap[0]), 32'd16);
    chk("gap12_head_seq", 32'(cap[1][11:0]), 32'h482);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'hA5);
    n = 0;
    t = 0;
    while (n < 4 && t < 20) begin
      @(negedge clk);
      t++;
      if (sh[0]) n++;
    end
    chk("reset_shifts_seen", 32'(n), 32'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_busy", 32'(bsy[0]), 32'd0);
    chk("midreset_ready", 32'(rdy[0]), 32'd0);
    chk("midreset_fres", 32'(fr[0]), 32'd1);
    chk("midreset_done", 32'(dn[0]), 32'd0);
    load(8'hA5, 8'h3C, 1'b0);
    chk("reload_head_seq", 32'(cap[0]), 32'hA53C);
    chk("reload_fres", 32'(fr[0]), 32'd0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
